// File: rtl/m555_pkg.sv
// Shared types and constants for the m555 timer.
// The optional edge strobes are controlled by the M555_EDGE_PULSE_EN macro in m555_timer.
package m555_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } state_e;

    localparam logic M555_ASTABLE    = 1'b0;
    localparam logic M555_MONOSTABLE = 1'b1;

    localparam int unsigned M555_DEFAULT_LEN = 50;

endpackage

// File: rtl/m555_phase_counter.sv
// Loadable down-counter timing one phase of the m555 timer.
// Loads len-1 (0 for len==0), counts down to 0 and holds there; done_o flags zero.
module m555_phase_counter
    import m555_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] len_i,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (len_i == '0) ? '0 : len_i - One;
        end else if (count_q != '0) begin
            count_d = count_q - One;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/m555_timer.sv
// Synchronous 555-style timer: astable clock generator or non-retriggerable one-shot.
// Define M555_EDGE_PULSE_EN to add the registered rise_pulse/fall_pulse strobes.
module m555_timer
    import m555_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             trigger,
    input  logic [WIDTH-1:0] high_len,
    input  logic [WIDTH-1:0] low_len,
    output logic             clk_out,
    output logic             busy
`ifdef M555_EDGE_PULSE_EN
    ,
    output logic             rise_pulse,
    output logic             fall_pulse
`endif
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic             clk_out_q, clk_out_d;
    logic             load;
    logic [WIDTH-1:0] load_len;
    logic             done;

    m555_phase_counter #(
        .WIDTH (WIDTH)
    ) u_phase_counter (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .load_i (load),
        .len_i  (load_len),
        .done_o (done)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        load     = 1'b0;
        load_len = high_len;
        unique case (state_q)
            StIdle: begin
                // Mode is only tracked while idle so a running phase keeps its mode.
                mode_d = mode;
                if ((mode == M555_MONOSTABLE) ? trigger : enable) begin
                    state_d = StHigh;
                    load    = 1'b1;
                end
            end
            StHigh: begin
                if (done) begin
                    if (mode_q == M555_ASTABLE) begin
                        state_d  = StLow;
                        load     = 1'b1;
                        load_len = low_len;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StLow: begin
                if (done) begin
                    if (enable) begin
                        state_d = StHigh;
                        load    = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        clk_out_d = (state_d == StHigh);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= StIdle;
            mode_q    <= M555_ASTABLE;
            clk_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign clk_out = clk_out_q;
    assign busy    = (state_q != StIdle);

`ifdef M555_EDGE_PULSE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Strobes are registered alongside clk_out so they line up with its transition.
    always_comb begin
        rise_d = clk_out_d & ~clk_out_q;
        fall_d = ~clk_out_d & clk_out_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`endif

endmodule

// File: tb/tb_m555_timer.sv
// Self-checking bench for m555_timer: directed scenarios plus random stimulus vs a waveform-queue model.
// Edge strobe checks are included when M555_EDGE_PULSE_EN is defined.
module tb_m555_timer;

    localparam int unsigned WIDTH = 16;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             enable;
    logic             mode;
    logic             trigger;
    logic [WIDTH-1:0] high_len;
    logic [WIDTH-1:0] low_len;
    logic             clk_out;
    logic             busy;
`ifdef M555_EDGE_PULSE_EN
    logic             rise_pulse;
    logic             fall_pulse;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: queue of the clk_out values still to come in the current phase.
    bit   wave_q[$];
    logic m_mode   = 1'b0;
    logic exp_out  = 1'b0;
    logic exp_busy = 1'b0;
    logic exp_rise = 1'b0;
    logic exp_fall = 1'b0;

    m555_timer #(
        .WIDTH (WIDTH)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .enable     (enable),
        .mode       (mode),
        .trigger    (trigger),
        .high_len   (high_len),
        .low_len    (low_len),
        .clk_out    (clk_out),
        .busy       (busy)
`ifdef M555_EDGE_PULSE_EN
        ,
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_len(input logic [WIDTH-1:0] len);
        return (len == '0) ? 1 : int'(len);
    endfunction

    task automatic push_phase(input bit v, input logic [WIDTH-1:0] len);
        for (int i = 0; i < eff_len(len); i++) wave_q.push_back(v);
    endtask

    task automatic model_step();
        bit   last;
        logic prev;
        prev = exp_out;
        if (Reset) begin
            wave_q.delete();
            prev = 1'b0;
        end else if (wave_q.size() == 0) begin
            if (mode ? trigger : enable) begin
                m_mode = mode;
                push_phase(1'b1, high_len);
            end
        end else begin
            last = wave_q.pop_front();
            if (wave_q.size() == 0 && m_mode == 1'b0) begin
                if (last) push_phase(1'b0, low_len);
                else if (enable) push_phase(1'b1, high_len);
            end
        end
        exp_busy = (wave_q.size() != 0);
        exp_out  = exp_busy ? wave_q[0] : 1'b0;
        exp_rise = exp_out & ~prev;
        exp_fall = ~exp_out & prev;
    endtask

    task automatic tick();
        @(posedge Clock);
        model_step();
        #1;
        check_eq("clk_out", {31'd0, clk_out}, {31'd0, exp_out});
        check_eq("busy", {31'd0, busy}, {31'd0, exp_busy});
`ifdef M555_EDGE_PULSE_EN
        check_eq("rise_pulse", {31'd0, rise_pulse}, {31'd0, exp_rise});
        check_eq("fall_pulse", {31'd0, fall_pulse}, {31'd0, exp_fall});
`endif
    endtask

    initial begin
        int ones;
        Reset    = 1'b1;
        enable   = 1'b1;
        mode     = 1'b0;
        trigger  = 1'b0;
        high_len = 16'd3;
        low_len  = 16'd2;

        repeat (3) begin
            tick();
            check_eq("reset_clk_out", {31'd0, clk_out}, 32'd0);
        end
        Reset = 1'b0;

        ones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) check_eq("first_high", {31'd0, clk_out}, 32'd1);
            ones += int'(clk_out);
        end
        check_eq("astable_ones", ones, 32'd12);

        // Drop enable during the second HIGH cycle of the next period.
        tick();
        tick();
        enable = 1'b0;
        ones = 0;
        repeat (6) begin
            tick();
            ones += int'(clk_out);
        end
        check_eq("stop_tail_ones", ones, 32'd1);
        check_eq("stop_idle_busy", {31'd0, busy}, 32'd0);

        mode     = 1'b1;
        high_len = 16'd4;
        trigger  = 1'b1;
        ones     = 0;
        tick();
        ones += int'(clk_out);
        trigger = 1'b0;
        tick();
        ones += int'(clk_out);
        trigger = 1'b1;
        tick();
        ones += int'(clk_out);
        trigger = 1'b0;
        repeat (7) begin
            tick();
            ones += int'(clk_out);
        end
        check_eq("mono_ones", ones, 32'd4);

        mode     = 1'b0;
        high_len = 16'd0;
        low_len  = 16'd0;
        enable   = 1'b1;
        ones     = 0;
        repeat (8) begin
            tick();
            ones += int'(clk_out);
        end
        check_eq("zero_len_ones", ones, 32'd4);

        high_len = 16'd2;
        low_len  = 16'd2;
        repeat (12) tick();
        enable = 1'b0;
        repeat (6) tick();

        for (int i = 0; i < 3000; i++) begin
            Reset   = ($urandom_range(0, 63) == 0);
            trigger = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) enable = ~enable;
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) high_len = WIDTH'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) low_len = WIDTH'($urandom_range(0, 5));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
